stage_flow_ctrl: RTL and testbench

Credit-based flow-control shell for the next-generation RMT stage. It sits around a fixed-latency stage datapath (key extract → lookup → action) and replaces the unused `stg_ready` with real valid/ready backpressure. PHVs are admitted only when output-FIFO space is guaranteed, and admission is held while a control packet addressed to this stage is in flight. Results are buffered in a parametrised output FIFO so the downstream stage can stall without losing PHVs.

---
 rtl/stage_flow_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_stage_flow_ctrl.sv | 562 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_flow_ctrl.sv
// stage_flow_ctrl: credit-based valid/ready shell around a fixed-latency RMT
// stage datapath. PHVs are admitted only when an output FIFO slot is already
// reserved for their result. Admission is held while a control packet for this
// stage is being applied. The control path is forwarded with one register stage.
// Optional feature: define STAGE_PERF_CNT_EN to add the perf_phv_cnt and
// perf_stall_cnt counter ports.

module stage_flow_ctrl #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int PHV_LEN              = 1124,
  parameter int STAGE_ID             = 0,
  parameter int STAGE_LAT            = 8,
  parameter int OUT_DEPTH            = 16,
  parameter int CTRL_ID_LSB          = 112
) (
  input  logic                              axis_clk,
  input  logic                              aresetn,
  input  logic [PHV_LEN-1:0]                phv_in,
  input  logic                              phv_in_valid,
  output logic                              phv_in_ready,
  output logic [PHV_LEN-1:0]                dp_phv_in,
  output logic                              dp_phv_in_valid,
  input  logic [PHV_LEN-1:0]                dp_phv_out,
  input  logic                              dp_phv_out_valid,
  output logic [PHV_LEN-1:0]                phv_out,
  output logic                              phv_out_valid,
  input  logic                              phv_out_ready,
  output logic                              cfg_quiet,
  output logic                              ovf_err,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_phv_cnt,
  output logic [31:0]                       perf_stall_cnt
`endif
);

  localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(OUT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [4:0]       MY_ID     = 5'(STAGE_ID);

  // The datapath latency only matters to the stage wrapper; the credit scheme
  // here is latency-agnostic, so an invalid value simply elaborates nothing.
  if (STAGE_LAT < 1) begin : g_stage_lat_unsupported
  end

  typedef enum logic {
    ST_IDLE,
    ST_CFG
  } state_t;

  state_t                     state_q, state_d;
  logic                       first_beat_q, first_beat_d;
  logic                       tlast_seen_q, tlast_seen_d;
  logic [CNT_W-1:0]           inflight_q, inflight_d;
  logic [CNT_W-1:0]           occ_q, occ_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic                       ovf_err_q, ovf_err_d;
  logic [PHV_LEN-1:0]         mem_q [OUT_DEPTH];

  logic [C_S_AXIS_DATA_WIDTH-1:0]  c_tdata_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] c_tuser_q;
  logic [KEEP_W-1:0]               c_tkeep_q;
  logic                            c_tvalid_q;
  logic                            c_tlast_q;

  logic issue;
  logic pop;
  logic full;
  logic fifo_wr;
  logic result_ret;
  logic ctrl_match;

  // Admission: a PHV may enter only if every in-flight result plus the FIFO
  // contents still leaves a free slot, and no configuration is in progress.
  assign phv_in_ready    = (({1'b0, occ_q} + {1'b0, inflight_q}) < {1'b0, DEPTH_CNT})
                           && (state_q == ST_IDLE);
  assign issue           = phv_in_valid & phv_in_ready;
  assign dp_phv_in       = phv_in;
  assign dp_phv_in_valid = issue;

  assign phv_out_valid = (occ_q != '0);
  assign phv_out       = mem_q[rd_ptr_q];
  assign pop           = phv_out_valid & phv_out_ready;
  assign full          = (occ_q == DEPTH_CNT);
  // A full FIFO can still take a result in the same cycle as a pop.
  assign fifo_wr       = dp_phv_out_valid & (~full | pop);
  // A result with nothing in flight is spurious and must not underflow the count.
  assign result_ret    = dp_phv_out_valid & (inflight_q != '0);

  assign ctrl_match = c_s_axis_tvalid & first_beat_q
                      & (c_s_axis_tdata[CTRL_ID_LSB +: 5] == MY_ID);

  assign cfg_quiet = (state_q == ST_CFG) && (inflight_q == '0);
  assign ovf_err   = ovf_err_q;

  assign c_m_axis_tdata  = c_tdata_q;
  assign c_m_axis_tuser  = c_tuser_q;
  assign c_m_axis_tkeep  = c_tkeep_q;
  assign c_m_axis_tvalid = c_tvalid_q;
  assign c_m_axis_tlast  = c_tlast_q;

  // Next values of the credit counters, FIFO pointers and sticky overflow flag.
  always_comb begin
    inflight_d = inflight_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_err_d  = ovf_err_q | (dp_phv_out_valid & full & ~pop);

    case ({issue, result_ret})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase

    case ({fifo_wr, pop})
      2'b10:   occ_d = occ_q + CNT_ONE;
      2'b01:   occ_d = occ_q - CNT_ONE;
      default: occ_d = occ_q;
    endcase

    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Control FSM: enter CFG on a first beat addressed to us, leave once the
  // packet has ended and the datapath holds no PHVs.
  always_comb begin
    state_d      = state_q;
    tlast_seen_d = tlast_seen_q;
    first_beat_d = first_beat_q;

    if (c_s_axis_tvalid) begin
      first_beat_d = c_s_axis_tlast;
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_match) begin
          state_d      = ST_CFG;
          tlast_seen_d = c_s_axis_tlast;
        end
      end
      ST_CFG: begin
        if (ctrl_match) begin
          tlast_seen_d = c_s_axis_tlast;
        end else if (c_s_axis_tvalid && c_s_axis_tlast) begin
          tlast_seen_d = 1'b1;
        end
        if (tlast_seen_d && (inflight_q == '0)) begin
          state_d      = ST_IDLE;
          tlast_seen_d = 1'b0;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        tlast_seen_d = 1'b0;
      end
    endcase
  end

  // State, counters, pointers and the control-path register stage.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      first_beat_q <= 1'b1;
      tlast_seen_q <= 1'b0;
      inflight_q   <= '0;
      occ_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_err_q    <= 1'b0;
      c_tdata_q    <= '0;
      c_tuser_q    <= '0;
      c_tkeep_q    <= '0;
      c_tvalid_q   <= 1'b0;
      c_tlast_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_beat_q <= first_beat_d;
      tlast_seen_q <= tlast_seen_d;
      inflight_q   <= inflight_d;
      occ_q        <= occ_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_err_q    <= ovf_err_d;
      c_tdata_q    <= c_s_axis_tdata;
      c_tuser_q    <= c_s_axis_tuser;
      c_tkeep_q    <= c_s_axis_tkeep;
      c_tvalid_q   <= c_s_axis_tvalid;
      c_tlast_q    <= c_s_axis_tlast;
    end
  end

  // FIFO storage; contents are discarded on reset by clearing the pointers.
  always_ff @(posedge axis_clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q] <= dp_phv_out;
    end
  end

`ifdef STAGE_PERF_CNT_EN
  logic [31:0] perf_phv_cnt_q, perf_phv_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  // Free-running, wrapping counts of issued PHVs and upstream stall cycles.
  always_comb begin
    perf_phv_cnt_d   = perf_phv_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (issue) begin
      perf_phv_cnt_d = perf_phv_cnt_q + 32'd1;
    end
    if (phv_in_valid && !phv_in_ready) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      perf_phv_cnt_q   <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_phv_cnt_q   <= perf_phv_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_phv_cnt   = perf_phv_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_stage_flow_ctrl.sv
// Testbench for stage_flow_ctrl: a latency-8 datapath model feeds results back,
// and a queue-based reference model predicts admission, FIFO output and control
// behaviour from the block's rules.

module tb_stage_flow_ctrl;

  localparam int DW     = 512;
  localparam int UW     = 128;
  localparam int KW     = DW / 8;
  localparam int PL     = 1124;
  localparam int DEPTH  = 16;
  localparam int LAT    = 8;
  localparam int ID_LSB = 112;
  localparam logic [4:0] SID = 5'd0;

  logic axis_clk = 1'b0;
  logic aresetn;
  always #5 axis_clk = ~axis_clk;

  logic [PL-1:0] phv_in;
  logic          phv_in_valid;
  logic          phv_in_ready;
  logic [PL-1:0] dp_phv_in;
  logic          dp_phv_in_valid;
  logic [PL-1:0] dp_phv_out;
  logic          dp_phv_out_valid;
  logic [PL-1:0] phv_out;
  logic          phv_out_valid;
  logic          phv_out_ready;
  logic          cfg_quiet;
  logic          ovf_err;
  logic [DW-1:0] c_s_axis_tdata,  c_m_axis_tdata;
  logic [UW-1:0] c_s_axis_tuser,  c_m_axis_tuser;
  logic [KW-1:0] c_s_axis_tkeep,  c_m_axis_tkeep;
  logic          c_s_axis_tvalid, c_m_axis_tvalid;
  logic          c_s_axis_tlast,  c_m_axis_tlast;
`ifdef STAGE_PERF_CNT_EN
  logic [31:0]   perf_phv_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  stage_flow_ctrl #(
    .C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .PHV_LEN(PL),
    .STAGE_ID(0), .STAGE_LAT(LAT), .OUT_DEPTH(DEPTH), .CTRL_ID_LSB(ID_LSB)
  ) dut (
    .axis_clk(axis_clk), .aresetn(aresetn),
    .phv_in(phv_in), .phv_in_valid(phv_in_valid), .phv_in_ready(phv_in_ready),
    .dp_phv_in(dp_phv_in), .dp_phv_in_valid(dp_phv_in_valid),
    .dp_phv_out(dp_phv_out), .dp_phv_out_valid(dp_phv_out_valid),
    .phv_out(phv_out), .phv_out_valid(phv_out_valid), .phv_out_ready(phv_out_ready),
    .cfg_quiet(cfg_quiet), .ovf_err(ovf_err),
    .c_s_axis_tdata(c_s_axis_tdata), .c_s_axis_tuser(c_s_axis_tuser),
    .c_s_axis_tkeep(c_s_axis_tkeep), .c_s_axis_tvalid(c_s_axis_tvalid),
    .c_s_axis_tlast(c_s_axis_tlast),
    .c_m_axis_tdata(c_m_axis_tdata), .c_m_axis_tuser(c_m_axis_tuser),
    .c_m_axis_tkeep(c_m_axis_tkeep), .c_m_axis_tvalid(c_m_axis_tvalid),
    .c_m_axis_tlast(c_m_axis_tlast)
`ifdef STAGE_PERF_CNT_EN
    , .perf_phv_cnt(perf_phv_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Fixed-latency datapath stand-in, plus a hook for injecting spurious results.
  logic          dp_pipe_v [LAT];
  logic [PL-1:0] dp_pipe_d [LAT];
  logic          spur_valid;
  logic [PL-1:0] spur_data;

  always @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < LAT; i++) dp_pipe_v[i] <= 1'b0;
    end else begin
      dp_pipe_v[0] <= dp_phv_in_valid;
      dp_pipe_d[0] <= dp_phv_in;
      for (int i = 1; i < LAT; i++) begin
        dp_pipe_v[i] <= dp_pipe_v[i-1];
        dp_pipe_d[i] <= dp_pipe_d[i-1];
      end
    end
  end

  assign dp_phv_out_valid = dp_pipe_v[LAT-1] | spur_valid;
  assign dp_phv_out       = spur_valid ? spur_data : dp_pipe_d[LAT-1];

  // Reference model state.
  logic [PL-1:0] m_q [$];
  int            m_inflight;
  bit            m_pv [LAT];
  logic [PL-1:0] m_pd [LAT];
  bit            m_cfg, m_first, m_end, m_ovf;
  int            m_phv_cnt, m_stall;
  logic [DW-1:0] p_tdata;
  logic [UW-1:0] p_tuser;
  logic [KW-1:0] p_tkeep;
  logic          p_tvalid, p_tlast;

  int total = 0;
  int bad   = 0;

  function automatic bit model_ready();
    return ((m_q.size() + m_inflight) < DEPTH) && !m_cfg;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_inflight = 0;
    for (int i = 0; i < LAT; i++) m_pv[i] = 1'b0;
    m_cfg = 0; m_first = 1; m_end = 0; m_ovf = 0;
    m_phv_cnt = 0; m_stall = 0;
    p_tdata = '0; p_tuser = '0; p_tkeep = '0; p_tvalid = 1'b0; p_tlast = 1'b0;
  endtask

  // Advance the model by one clock using only bench-driven inputs, then step
  // to 1 time unit after the next rising edge.
  task automatic tick();
    bit rdy, acc, res_v, pop, match, was_cfg;
    logic [PL-1:0] res_d;
    int infl_before;
    rdy         = model_ready();
    acc         = phv_in_valid && rdy;
    res_v       = m_pv[LAT-1] || spur_valid;
    res_d       = spur_valid ? spur_data : m_pd[LAT-1];
    pop         = (m_q.size() != 0) && phv_out_ready;
    infl_before = m_inflight;
    if (res_v && m_q.size() == DEPTH && !pop) m_ovf = 1;
    if (pop) void'(m_q.pop_front());
    if (res_v && m_q.size() < DEPTH) m_q.push_back(res_d);
    m_inflight = m_inflight + int'(acc) - ((res_v && infl_before > 0) ? 1 : 0);
    for (int i = LAT - 1; i > 0; i--) begin
      m_pv[i] = m_pv[i-1];
      m_pd[i] = m_pd[i-1];
    end
    m_pv[0] = acc;
    m_pd[0] = phv_in;
    if (acc) m_phv_cnt++;
    if (phv_in_valid && !rdy) m_stall++;
    was_cfg = m_cfg;
    match   = c_s_axis_tvalid && m_first && (c_s_axis_tdata[ID_LSB +: 5] == SID);
    if (!was_cfg) begin
      if (match) begin m_cfg = 1; m_end = c_s_axis_tlast; end
    end else begin
      if (match) m_end = c_s_axis_tlast;
      else if (c_s_axis_tvalid && c_s_axis_tlast) m_end = 1;
      if (m_end && infl_before == 0) begin m_cfg = 0; m_end = 0; end
    end
    if (c_s_axis_tvalid) m_first = c_s_axis_tlast;
    p_tdata = c_s_axis_tdata; p_tuser = c_s_axis_tuser; p_tkeep = c_s_axis_tkeep;
    p_tvalid = c_s_axis_tvalid; p_tlast = c_s_axis_tlast;
    @(posedge axis_clk);
    #1;
  endtask

  task automatic rand_phv();
    for (int i = 0; i < PL / 32; i++) phv_in[i*32 +: 32] = $urandom;
    phv_in[PL-1 -: 4] = 4'($urandom);
  endtask

  task automatic set_ctrl(input bit v, input bit l, input logic [4:0] id);
    for (int i = 0; i < DW / 32; i++) c_s_axis_tdata[i*32 +: 32] = $urandom;
    for (int i = 0; i < UW / 32; i++) c_s_axis_tuser[i*32 +: 32] = $urandom;
    for (int i = 0; i < KW / 32; i++) c_s_axis_tkeep[i*32 +: 32] = $urandom;
    c_s_axis_tdata[ID_LSB +: 5] = id;
    c_s_axis_tvalid = v;
    c_s_axis_tlast  = l;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    phv_in_valid = 1'b0; phv_out_ready = 1'b0; spur_valid = 1'b0;
    phv_in = '0; spur_data = '0;
    set_ctrl(1'b0, 1'b0, 5'd0);
    model_reset();
    repeat (2) @(posedge axis_clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    total++;
    if ({phv_out_valid, ovf_err, cfg_quiet, phv_in_ready} !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b expected 0001",
               {phv_out_valid, ovf_err, cfg_quiet, phv_in_ready});
    end
    total++;
    if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl_out: got tvalid=%b tlast=%b expected all zero",
               c_m_axis_tvalid, c_m_axis_tlast);
    end
`ifdef STAGE_PERF_CNT_EN
    total++;
    if ({perf_phv_cnt, perf_stall_cnt} !== 64'd0) begin
      bad++;
      $display("[TB] FAIL reset_perf: got %0h/%0h expected 0/0", perf_phv_cnt, perf_stall_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_back_to_back();
    int first_acc = -1, first_out = -1, outs = 0, n_in = 0;
    do_reset();
    phv_out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      phv_in_valid = (n_in < 10);
      rand_phv();
      #2;
      total++;
      if (phv_in_ready !== 1'b1) begin
        bad++; $display("[TB] FAIL b2b_ready c=%0d: got %b expected 1", c, phv_in_ready);
      end
      total++;
      if (phv_out_valid !== (m_q.size() != 0)) begin
        bad++; $display("[TB] FAIL b2b_out_valid c=%0d: got %b expected %b", c, phv_out_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        total++;
        if (phv_out !== m_q[0]) begin
          bad++; $display("[TB] FAIL b2b_data c=%0d: got %0h expected %0h", c, phv_out, m_q[0]);
        end
      end
      if (dp_phv_in_valid && first_acc < 0) first_acc = c;
      if (phv_out_valid && first_out < 0) first_out = c;
      if (phv_out_valid) outs++;
      if (phv_in_valid) n_in++;
      tick();
    end
    phv_in_valid = 1'b0;
    total++;
    if (first_out - first_acc !== 9) begin
      bad++; $display("[TB] FAIL b2b_latency: got %0d expected 9", first_out - first_acc);
    end
    total++;
    if (outs !== 10) begin
      bad++; $display("[TB] FAIL b2b_count: got %0d expected 10", outs);
    end
  endtask

  task automatic test_fill();
    int acc = 0, acc2 = 0;
    do_reset();
    phv_in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      rand_phv();
      #2;
      total++;
      if (phv_in_ready !== model_ready()) begin
        bad++; $display("[TB] FAIL fill_ready c=%0d: got %b expected %b", c, phv_in_ready, model_ready());
      end
      if (dp_phv_in_valid) acc++;
      tick();
    end
    #2;
    total++;
    if (acc !== DEPTH) begin
      bad++; $display("[TB] FAIL fill_accepts: got %0d expected %0d", acc, DEPTH);
    end
    total++;
    if (phv_in_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL fill_ready_low: got %b expected 0", phv_in_ready);
    end
    phv_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      rand_phv();
      #1;
      if (dp_phv_in_valid) acc2++;
      tick();
      phv_out_ready = 1'b0;
    end
    total++;
    if (acc2 !== 1) begin
      bad++; $display("[TB] FAIL fill_one_more: got %0d expected 1", acc2);
    end
    phv_in_valid = 1'b0;
    phv_out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #2;
      total++;
      if (phv_out_valid !== (m_q.size() != 0)) begin
        bad++; $display("[TB] FAIL fill_drain_valid c=%0d: got %b expected %b", c, phv_out_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        total++;
        if (phv_out !== m_q[0]) begin
          bad++; $display("[TB] FAIL fill_drain_data c=%0d: got %0h expected %0h", c, phv_out, m_q[0]);
        end
      end
      tick();
    end
    total++;
    if (ovf_err !== 1'b0) begin
      bad++; $display("[TB] FAIL fill_ovf: got %b expected 0", ovf_err);
    end
  endtask

  task automatic test_full_write_pop();
    do_reset();
    phv_in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin rand_phv(); tick(); end
    phv_in_valid = 1'b0;
    repeat (12) tick();
    spur_valid = 1'b1;
    for (int i = 0; i < PL / 32; i++) spur_data[i*32 +: 32] = $urandom;
    phv_out_ready = 1'b1;
    #2;
    total++;
    if (phv_out !== m_q[0]) begin
      bad++; $display("[TB] FAIL full_pop_data: got %0h expected %0h", phv_out, m_q[0]);
    end
    tick();
    spur_valid = 1'b0;
    phv_out_ready = 1'b0;
    #2;
    total++;
    if ({ovf_err, phv_out_valid, phv_in_ready} !== 3'b010) begin
      bad++; $display("[TB] FAIL full_simul: got ovf/valid/ready=%b expected 010",
                      {ovf_err, phv_out_valid, phv_in_ready});
    end
    spur_valid = 1'b1;
    spur_data  = ~spur_data;
    tick();
    spur_valid = 1'b0;
    phv_out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #2;
      total++;
      if (ovf_err !== 1'b1) begin
        bad++; $display("[TB] FAIL ovf_sticky c=%0d: got %b expected 1", c, ovf_err);
      end
      if (m_q.size() != 0) begin
        total++;
        if (phv_out !== m_q[0]) begin
          bad++; $display("[TB] FAIL ovf_drain_data c=%0d: got %0h expected %0h", c, phv_out, m_q[0]);
        end
      end
      tick();
    end
  endtask

  task automatic test_ctrl_match();
    bit quiet_seen = 0;
    do_reset();
    phv_out_ready = 1'b1;
    phv_in_valid  = 1'b1;
    for (int c = 0; c < 30; c++) begin
      rand_phv();
      if (c == 4)      set_ctrl(1'b1, 1'b0, SID);
      else if (c == 5) set_ctrl(1'b1, 1'b0, 5'($urandom));
      else if (c == 6) set_ctrl(1'b1, 1'b1, 5'($urandom));
      else             set_ctrl(1'b0, 1'b0, 5'($urandom));
      #2;
      total++;
      if (phv_in_ready !== model_ready()) begin
        bad++; $display("[TB] FAIL cfg_ready c=%0d: got %b expected %b", c, phv_in_ready, model_ready());
      end
      total++;
      if (cfg_quiet !== (m_cfg && m_inflight == 0)) begin
        bad++; $display("[TB] FAIL cfg_quiet c=%0d: got %b expected %b", c, cfg_quiet, m_cfg && m_inflight == 0);
      end
      total++;
      if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast}
          !== {p_tdata, p_tuser, p_tkeep, p_tvalid, p_tlast}) begin
        bad++; $display("[TB] FAIL cfg_passthru c=%0d: got v=%b l=%b expected v=%b l=%b",
                        c, c_m_axis_tvalid, c_m_axis_tlast, p_tvalid, p_tlast);
      end
      if (c == 4) begin
        total++;
        if (dp_phv_in_valid !== 1'b1) begin
          bad++; $display("[TB] FAIL cfg_same_cycle_issue: got %b expected 1", dp_phv_in_valid);
        end
      end
      if (c == 5) begin
        total++;
        if (phv_in_ready !== 1'b0) begin
          bad++; $display("[TB] FAIL cfg_ready_drop: got %b expected 0", phv_in_ready);
        end
      end
      if (cfg_quiet) quiet_seen = 1;
      tick();
    end
    #2;
    total++;
    if ({quiet_seen, phv_in_ready} !== 2'b11) begin
      bad++; $display("[TB] FAIL cfg_exit: got quiet_seen/ready=%b expected 11", {quiet_seen, phv_in_ready});
    end
    phv_in_valid = 1'b0;
  endtask

  task automatic test_ctrl_other();
    do_reset();
    phv_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      phv_in_valid = 1'($urandom);
      rand_phv();
      if (c == 2)      set_ctrl(1'b1, 1'b0, SID + 5'd1);
      else if (c == 3) set_ctrl(1'b1, 1'b0, SID);
      else if (c == 4) set_ctrl(1'b1, 1'b1, SID);
      else             set_ctrl(1'b0, 1'b0, 5'($urandom));
      #2;
      total++;
      if (phv_in_ready !== 1'b1) begin
        bad++; $display("[TB] FAIL other_ready c=%0d: got %b expected 1", c, phv_in_ready);
      end
      total++;
      if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast}
          !== {p_tdata, p_tuser, p_tkeep, p_tvalid, p_tlast}) begin
        bad++; $display("[TB] FAIL other_passthru c=%0d: got v=%b l=%b expected v=%b l=%b",
                        c, c_m_axis_tvalid, c_m_axis_tlast, p_tvalid, p_tlast);
      end
      tick();
    end
    phv_in_valid = 1'b0;
  endtask

  task automatic test_random();
    int beats_left = 0;
    bit new_pkt = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      phv_in_valid  = ($urandom % 4) != 0;
      phv_out_ready = ($urandom % 3) != 0;
      rand_phv();
      if (beats_left == 0 && ($urandom % 16) == 0) begin
        beats_left = 1 + int'($urandom % 4);
        new_pkt = 1;
      end
      if (beats_left > 0 && ($urandom % 3) != 0) begin
        set_ctrl(1'b1, beats_left == 1,
                 new_pkt ? ((($urandom % 2) != 0) ? SID : SID + 5'd1) : 5'($urandom));
        beats_left--;
        new_pkt = 0;
      end else begin
        set_ctrl(1'b0, 1'($urandom), 5'($urandom));
      end
      #2;
      total++;
      if (phv_in_ready !== model_ready()) begin
        bad++; $display("[TB] FAIL rnd_ready c=%0d: got %b expected %b", c, phv_in_ready, model_ready());
      end
      total++;
      if (dp_phv_in_valid !== (phv_in_valid && model_ready())) begin
        bad++; $display("[TB] FAIL rnd_issue c=%0d: got %b expected %b", c, dp_phv_in_valid, phv_in_valid && model_ready());
      end
      total++;
      if (phv_out_valid !== (m_q.size() != 0)) begin
        bad++; $display("[TB] FAIL rnd_out_valid c=%0d: got %b expected %b", c, phv_out_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
        total++;
        if (phv_out !== m_q[0]) begin
          bad++; $display("[TB] FAIL rnd_data c=%0d: got %0h expected %0h", c, phv_out, m_q[0]);
        end
      end
      total++;
      if ({cfg_quiet, ovf_err} !== {m_cfg && m_inflight == 0, m_ovf}) begin
        bad++; $display("[TB] FAIL rnd_quiet_ovf c=%0d: got %b expected %b", c,
                        {cfg_quiet, ovf_err}, {m_cfg && m_inflight == 0, m_ovf});
      end
      total++;
      if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast}
          !== {p_tdata, p_tuser, p_tkeep, p_tvalid, p_tlast}) begin
        bad++; $display("[TB] FAIL rnd_passthru c=%0d: got v=%b l=%b expected v=%b l=%b",
                        c, c_m_axis_tvalid, c_m_axis_tlast, p_tvalid, p_tlast);
      end
`ifdef STAGE_PERF_CNT_EN
      total++;
      if ({perf_phv_cnt, perf_stall_cnt} !== {32'(m_phv_cnt), 32'(m_stall)}) begin
        bad++; $display("[TB] FAIL rnd_perf c=%0d: got %0d/%0d expected %0d/%0d", c,
                        perf_phv_cnt, perf_stall_cnt, m_phv_cnt, m_stall);
      end
`endif
      tick();
    end
    phv_in_valid = 1'b0;
    set_ctrl(1'b0, 1'b0, 5'd0);
  endtask

`ifdef STAGE_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    phv_in_valid = 1'b1;
    for (int c = 0; c < 23; c++) begin rand_phv(); tick(); end
    phv_in_valid  = 1'b0;
    phv_out_ready = 1'b1;
    repeat (12) tick();
    phv_in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin rand_phv(); tick(); end
    phv_in_valid = 1'b0;
    #2;
    total++;
    if ({perf_phv_cnt, perf_stall_cnt} !== {32'd20, 32'd7}) begin
      bad++; $display("[TB] FAIL perf_counts: got %0d/%0d expected 20/7", perf_phv_cnt, perf_stall_cnt);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    phv_in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin rand_phv(); tick(); end
    phv_in_valid = 1'b0;
    repeat (12) tick();
    spur_valid = 1'b1;
    spur_data  = '1;
    tick();
    spur_valid = 1'b0;
    set_ctrl(1'b1, 1'b0, SID);
    tick();
    set_ctrl(1'b1, 1'b0, 5'($urandom));
    #2;
    total++;
    if ({phv_out_valid, ovf_err, c_m_axis_tvalid} !== 3'b111) begin
      bad++; $display("[TB] FAIL midrst_pre: got %b expected 111", {phv_out_valid, ovf_err, c_m_axis_tvalid});
    end
    aresetn = 1'b0;
    #1;
    total++;
    if ({phv_out_valid, ovf_err, cfg_quiet, phv_in_ready} !== 4'b0001) begin
      bad++; $display("[TB] FAIL midrst_flags: got %b expected 0001",
                      {phv_out_valid, ovf_err, cfg_quiet, phv_in_ready});
    end
    total++;
    if ({c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep, c_m_axis_tvalid, c_m_axis_tlast} !== '0) begin
      bad++; $display("[TB] FAIL midrst_ctrl_out: got tvalid=%b tlast=%b expected all zero",
                      c_m_axis_tvalid, c_m_axis_tlast);
    end
`ifdef STAGE_PERF_CNT_EN
    total++;
    if ({perf_phv_cnt, perf_stall_cnt} !== 64'd0) begin
      bad++; $display("[TB] FAIL midrst_perf: got %0h/%0h expected 0/0", perf_phv_cnt, perf_stall_cnt);
    end
`endif
    do_reset();
    #2;
    total++;
    if ({phv_out_valid, cfg_quiet, phv_in_ready} !== 3'b001) begin
      bad++; $display("[TB] FAIL midrst_after: got %b expected 001", {phv_out_valid, cfg_quiet, phv_in_ready});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fill();
    test_full_write_pop();
    test_ctrl_match();
    test_ctrl_other();
    test_random();
`ifdef STAGE_PERF_CNT_EN
    test_perf();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
